t02_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single external RAM bus (Ren/Wen/ramaddr/ramstore/ramload/busy_o) between the CPU memory path and a secondary peripheral requester (e.g. display/DMA fetch). It sits between those requesters and the bus interface. It latches one request at a time and sequences it through issue, busy-wait and completion. It resolves simultaneous requests round-robin and aborts transactions that the bus never acknowledges.

---
 rtl/t02_mem_arbiter_if.sv | 51 +++++
 rtl/t02_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_t02_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/t02_mem_arbiter_if.sv
// ----------------------------------------------------------------
// t02_mem_arbiter_if: CPU, peripheral and RAM-bus signals of the arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface t02_mem_arbiter_if;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  logic        per_ren;
  logic        per_wen;
  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic [31:0] per_rdata;
  logic        per_ready;

  logic        busy_o;
  logic [31:0] ramload;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        timeout_err;

  // Arbiter view: requests and bus status in, strobes and completions out.
  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  per_ren, per_wen, per_addr, per_wdata,
    output per_rdata, per_ready,
    input  busy_o, ramload,
    output Ren, Wen, ramaddr, ramstore, timeout_err
  );

  // Environment view: requesters plus the RAM bus model.
  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output per_ren, per_wen, per_addr, per_wdata,
    input  per_rdata, per_ready,
    output busy_o, ramload,
    input  Ren, Wen, ramaddr, ramstore, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/t02_mem_arbiter.sv
// ----------------------------------------------------------------
// t02_mem_arbiter: round-robin CPU/peripheral arbiter for one RAM bus
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module t02_mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  t02_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_PER = 1'b1
  } grant_t;

  state_t             state_q, state_d;
  grant_t             grant_q, grant_d;
  grant_t             last_grant_q, last_grant_d;
  grant_t             pick;
  logic               is_write_q, is_write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               abort_q, abort_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [31:0]        per_rdata_q, per_rdata_d;

  logic cpu_act;
  logic per_act;
  logic in_bus_phase;

  assign cpu_act = bus.cpu_ren | bus.cpu_wen;
  assign per_act = bus.per_ren | bus.per_wen;
  assign cnt_inc = cnt_q + 1'b1;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    pick = GRANT_CPU;
    if (cpu_act && per_act) begin
      pick = (last_grant_q == GRANT_PER) ? GRANT_CPU : GRANT_PER;
    end else if (per_act) begin
      pick = GRANT_PER;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    cpu_rdata_d  = cpu_rdata_q;
    per_rdata_d  = per_rdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (cpu_act || per_act) begin
          grant_d = pick;
          if (pick == GRANT_CPU) begin
            is_write_d = bus.cpu_wen;
            addr_d     = bus.cpu_addr;
            wdata_d    = bus.cpu_wdata;
          end else begin
            is_write_d = bus.per_wen;
            addr_d     = bus.per_addr;
            wdata_d    = bus.per_wdata;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // busy_o wins over the timeout if both land on the same cycle.
        if (bus.busy_o) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT: begin
        if (!bus.busy_o) begin
          if (!is_write_q) begin
            if (grant_q == GRANT_CPU) begin
              cpu_rdata_d = bus.ramload;
            end else begin
              per_rdata_d = bus.ramload;
            end
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      grant_q      <= GRANT_CPU;
      last_grant_q <= GRANT_PER;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      cpu_rdata_q  <= '0;
      per_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      cpu_rdata_q  <= cpu_rdata_d;
      per_rdata_q  <= per_rdata_d;
    end
  end

  // All outputs decode straight from flops, so the bus sees no input-to-output paths.
  assign in_bus_phase    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.Ren         = in_bus_phase && !is_write_q;
  assign bus.Wen         = in_bus_phase && is_write_q;
  assign bus.ramaddr     = addr_q;
  assign bus.ramstore    = wdata_q;
  assign bus.cpu_ready   = (state_q == S_DONE) && (grant_q == GRANT_CPU);
  assign bus.per_ready   = (state_q == S_DONE) && (grant_q == GRANT_PER);
  assign bus.timeout_err = (state_q == S_DONE) && abort_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.per_rdata   = per_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_t02_mem_arbiter.sv
// ----------------------------------------------------------------
// tb_t02_mem_arbiter: directed self-checking bench for t02_mem_arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_t02_mem_arbiter;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  t02_mem_arbiter_if bus_if ();

  t02_mem_arbiter #(.TIMEOUT(16)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle starts 1 time unit after the rising edge; drive and sample there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    bus_if.cpu_ren  = 1'b1;
    bus_if.cpu_addr = 32'h0000_0ABC;
    tick();
    tick();
    checks++; if (bus_if.Ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %h expected 0", bus_if.Ren); end
    checks++; if (bus_if.Wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %h expected 0", bus_if.Wen); end
    checks++; if (bus_if.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready: got %h expected 0", bus_if.cpu_ready); end
    checks++; if (bus_if.per_ready !== 1'b0) begin errors++; $display("FAIL reset_per_ready: got %h expected 0", bus_if.per_ready); end
    checks++; if (bus_if.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %h expected 0", bus_if.timeout_err); end
    checks++; if (bus_if.ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr: got %h expected 0", bus_if.ramaddr); end
    checks++; if (bus_if.ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore: got %h expected 0", bus_if.ramstore); end
    checks++; if (bus_if.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 0", bus_if.cpu_rdata); end
    checks++; if (bus_if.per_rdata !== 32'h0) begin errors++; $display("FAIL reset_per_rdata: got %h expected 0", bus_if.per_rdata); end
    nrst = 1'b1;
    tick();
    checks++; if (bus_if.Ren !== 1'b1) begin errors++; $display("FAIL post_reset_ren: got %h expected 1", bus_if.Ren); end
    checks++; if (bus_if.ramaddr !== 32'h0000_0ABC) begin errors++; $display("FAIL post_reset_ramaddr: got %h expected 00000abc", bus_if.ramaddr); end
    bus_if.busy_o = 1'b1;
    tick();
    bus_if.busy_o  = 1'b0;
    bus_if.ramload = 32'h5555_AAAA;
    tick();
    checks++; if (bus_if.cpu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %h expected 1", bus_if.cpu_ready); end
    bus_if.cpu_ren = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read;
    bus_if.cpu_ren  = 1'b1;
    bus_if.cpu_addr = 32'h0000_0100;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      bus_if.busy_o  = (cyc >= 2 && cyc <= 4);
      bus_if.ramload = (cyc == 5) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      if (cyc == 6) bus_if.cpu_ren = 1'b0;
      checks++; if (bus_if.Ren !== (cyc <= 5)) begin errors++; $display("FAIL rd_ren c%0d: got %h expected %h", cyc, bus_if.Ren, (cyc <= 5)); end
      checks++; if (bus_if.cpu_ready !== (cyc == 6)) begin errors++; $display("FAIL rd_cpu_ready c%0d: got %h expected %h", cyc, bus_if.cpu_ready, (cyc == 6)); end
      checks++; if (bus_if.per_ready !== 1'b0) begin errors++; $display("FAIL rd_per_ready c%0d: got %h expected 0", cyc, bus_if.per_ready); end
    end
    checks++; if (bus_if.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_cpu_rdata: got %h expected deadbeef", bus_if.cpu_rdata); end
    tick();
    checks++; if (bus_if.ramaddr !== 32'h0000_0100) begin errors++; $display("FAIL rd_addr_hold: got %h expected 00000100", bus_if.ramaddr); end
    checks++; if (bus_if.cpu_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_once: got %h expected 0", bus_if.cpu_ready); end
  endtask

  task automatic test_per_write;
    bus_if.per_ren   = 1'b1;
    bus_if.per_wen   = 1'b1;
    bus_if.per_addr  = 32'h0000_0040;
    bus_if.per_wdata = 32'h1234_5678;
    bus_if.ramload   = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      bus_if.busy_o = (cyc <= 2);
      if (cyc == 4) begin
        bus_if.per_ren = 1'b0;
        bus_if.per_wen = 1'b0;
      end
      checks++; if (bus_if.Wen !== (cyc <= 3)) begin errors++; $display("FAIL wr_wen c%0d: got %h expected %h", cyc, bus_if.Wen, (cyc <= 3)); end
      checks++; if (bus_if.Ren !== 1'b0) begin errors++; $display("FAIL wr_ren c%0d: got %h expected 0", cyc, bus_if.Ren); end
      checks++; if (bus_if.ramstore !== 32'h1234_5678) begin errors++; $display("FAIL wr_ramstore c%0d: got %h expected 12345678", cyc, bus_if.ramstore); end
      checks++; if (bus_if.per_ready !== (cyc == 4)) begin errors++; $display("FAIL wr_per_ready c%0d: got %h expected %h", cyc, bus_if.per_ready, (cyc == 4)); end
      checks++; if (bus_if.cpu_ready !== 1'b0) begin errors++; $display("FAIL wr_cpu_ready c%0d: got %h expected 0", cyc, bus_if.cpu_ready); end
    end
    tick();
    checks++; if (bus_if.per_rdata !== 32'h0) begin errors++; $display("FAIL wr_per_rdata: got %h expected 0", bus_if.per_rdata); end
    checks++; if (bus_if.per_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_once: got %h expected 0", bus_if.per_ready); end
  endtask

  task automatic test_contention;
    logic [31:0] exp_addr;
    logic        exp_cpu;
    bus_if.cpu_ren  = 1'b1;
    bus_if.cpu_addr = 32'h0000_0200;
    bus_if.per_ren  = 1'b1;
    bus_if.per_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      exp_cpu  = (i % 2 == 0);
      exp_addr = exp_cpu ? 32'h0000_0200 : 32'h0000_0300;
      tick();
      checks++; if (bus_if.ramaddr !== exp_addr) begin errors++; $display("FAIL cont_addr a%0d: got %h expected %h", i, bus_if.ramaddr, exp_addr); end
      checks++; if (bus_if.Ren !== 1'b1) begin errors++; $display("FAIL cont_ren_issue a%0d: got %h expected 1", i, bus_if.Ren); end
      bus_if.busy_o = 1'b1;
      tick();
      tick();
      bus_if.busy_o  = 1'b0;
      bus_if.ramload = 32'hC0DE_0000 + i;
      tick();
      if (i == 3) begin
        bus_if.cpu_ren = 1'b0;
        bus_if.per_ren = 1'b0;
      end
      checks++; if (bus_if.Ren !== 1'b0) begin errors++; $display("FAIL cont_ren_done a%0d: got %h expected 0", i, bus_if.Ren); end
      checks++; if (bus_if.cpu_ready !== exp_cpu) begin errors++; $display("FAIL cont_cpu_ready a%0d: got %h expected %h", i, bus_if.cpu_ready, exp_cpu); end
      checks++; if (bus_if.per_ready !== !exp_cpu) begin errors++; $display("FAIL cont_per_ready a%0d: got %h expected %h", i, bus_if.per_ready, !exp_cpu); end
      tick();
      checks++; if (bus_if.Ren !== 1'b0) begin errors++; $display("FAIL cont_ren_idle a%0d: got %h expected 0", i, bus_if.Ren); end
    end
    checks++; if (bus_if.cpu_rdata !== 32'hC0DE_0002) begin errors++; $display("FAIL cont_cpu_rdata: got %h expected c0de0002", bus_if.cpu_rdata); end
    checks++; if (bus_if.per_rdata !== 32'hC0DE_0003) begin errors++; $display("FAIL cont_per_rdata: got %h expected c0de0003", bus_if.per_rdata); end
  endtask

  task automatic test_timeout;
    bus_if.cpu_ren  = 1'b1;
    bus_if.cpu_addr = 32'h0000_0500;
    bus_if.busy_o   = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      checks++; if (bus_if.Ren !== (cyc <= 15)) begin errors++; $display("FAIL to_ren c%0d: got %h expected %h", cyc, bus_if.Ren, (cyc <= 15)); end
      checks++; if (bus_if.cpu_ready !== (cyc == 16)) begin errors++; $display("FAIL to_ready c%0d: got %h expected %h", cyc, bus_if.cpu_ready, (cyc == 16)); end
      checks++; if (bus_if.timeout_err !== (cyc == 16)) begin errors++; $display("FAIL to_err c%0d: got %h expected %h", cyc, bus_if.timeout_err, (cyc == 16)); end
    end
    checks++; if (bus_if.cpu_rdata !== 32'hC0DE_0002) begin errors++; $display("FAIL to_rdata_kept: got %h expected c0de0002", bus_if.cpu_rdata); end
    bus_if.cpu_addr = 32'h0000_0504;
    tick();
    checks++; if (bus_if.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %h expected 0", bus_if.timeout_err); end
    tick();
    checks++; if (bus_if.ramaddr !== 32'h0000_0504) begin errors++; $display("FAIL to_next_addr: got %h expected 00000504", bus_if.ramaddr); end
    bus_if.busy_o = 1'b1;
    tick();
    bus_if.busy_o  = 1'b0;
    bus_if.ramload = 32'h0000_7777;
    tick();
    bus_if.cpu_ren = 1'b0;
    checks++; if (bus_if.cpu_ready !== 1'b1) begin errors++; $display("FAIL to_next_ready: got %h expected 1", bus_if.cpu_ready); end
    checks++; if (bus_if.timeout_err !== 1'b0) begin errors++; $display("FAIL to_next_err: got %h expected 0", bus_if.timeout_err); end
    checks++; if (bus_if.cpu_rdata !== 32'h0000_7777) begin errors++; $display("FAIL to_next_rdata: got %h expected 00007777", bus_if.cpu_rdata); end
    tick();
  endtask

  task automatic test_mid_reset;
    bus_if.per_ren  = 1'b1;
    bus_if.per_addr = 32'h0000_0600;
    tick();
    bus_if.busy_o = 1'b1;
    tick();
    bus_if.cpu_ren  = 1'b1;
    bus_if.cpu_addr = 32'h0000_0700;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    bus_if.busy_o = 1'b0;
    checks++; if (bus_if.Ren !== 1'b0) begin errors++; $display("FAIL mr_ren: got %h expected 0", bus_if.Ren); end
    checks++; if (bus_if.per_ready !== 1'b0) begin errors++; $display("FAIL mr_per_ready: got %h expected 0", bus_if.per_ready); end
    checks++; if (bus_if.ramaddr !== 32'h0) begin errors++; $display("FAIL mr_ramaddr: got %h expected 0", bus_if.ramaddr); end
    tick();
    checks++; if (bus_if.ramaddr !== 32'h0000_0700) begin errors++; $display("FAIL mr_cpu_first: got %h expected 00000700", bus_if.ramaddr); end
    checks++; if (bus_if.per_ready !== 1'b0) begin errors++; $display("FAIL mr_no_pulse: got %h expected 0", bus_if.per_ready); end
    bus_if.busy_o = 1'b1;
    tick();
    bus_if.busy_o  = 1'b0;
    bus_if.ramload = 32'h0000_1111;
    tick();
    bus_if.cpu_ren = 1'b0;
    checks++; if (bus_if.cpu_ready !== 1'b1) begin errors++; $display("FAIL mr_cpu_ready: got %h expected 1", bus_if.cpu_ready); end
    checks++; if (bus_if.per_ready !== 1'b0) begin errors++; $display("FAIL mr_per_idle: got %h expected 0", bus_if.per_ready); end
    tick();
    tick();
    checks++; if (bus_if.ramaddr !== 32'h0000_0600) begin errors++; $display("FAIL mr_per_regrant: got %h expected 00000600", bus_if.ramaddr); end
    bus_if.busy_o = 1'b1;
    tick();
    bus_if.busy_o  = 1'b0;
    bus_if.ramload = 32'h0000_2222;
    tick();
    bus_if.per_ren = 1'b0;
    checks++; if (bus_if.per_ready !== 1'b1) begin errors++; $display("FAIL mr_per_ready_end: got %h expected 1", bus_if.per_ready); end
    checks++; if (bus_if.per_rdata !== 32'h0000_2222) begin errors++; $display("FAIL mr_per_rdata: got %h expected 00002222", bus_if.per_rdata); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst              = 1'b0;
    bus_if.cpu_ren    = 1'b0;
    bus_if.cpu_wen    = 1'b0;
    bus_if.cpu_addr   = 32'h0;
    bus_if.cpu_wdata  = 32'h0;
    bus_if.per_ren    = 1'b0;
    bus_if.per_wen    = 1'b0;
    bus_if.per_addr   = 32'h0;
    bus_if.per_wdata  = 32'h0;
    bus_if.busy_o     = 1'b0;
    bus_if.ramload    = 32'h0;

    test_reset();
    test_cpu_read();
    test_per_write();
    test_contention();
    test_timeout();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
